// File: rtl/sha_const_fetch_pkg.sv
// Shared constants, state encoding and address helpers for the SHA-256 constant fetch block.
// Pure declarations: no latency, no flow control.
package sha_const_fetch_pkg;

  localparam int ADDR_W     = 13;
  localparam int IDX_W      = 6;
  localparam int DATA_W     = 32;
  localparam int LANE_W     = 8;
  localparam int H_BASE     = 0;
  localparam int K_BASE_DEF = 8;
  localparam int H_WORDS    = 8;
  localparam int K_WORDS    = 64;
  localparam int WAIT_DEF   = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_ACCESS  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_RESP    = 3'd4
  } state_e;

  // Every K index a 6-bit field can carry is legal; only the H table can overflow.
  function automatic logic idx_in_range(input logic sel, input logic [IDX_W-1:0] idx);
    return sel || (int'(idx) < H_WORDS);
  endfunction

  function automatic logic [ADDR_W-1:0] rom_addr(input logic sel, input logic [IDX_W-1:0] idx,
                                                 input int k_base);
    return sel ? ADDR_W'(k_base + int'(idx)) : ADDR_W'(H_BASE + int'(idx));
  endfunction

endpackage

// File: rtl/sha_const_fetch_if.sv
// Request/response bundle between the round engine (master) and the constant fetcher (slave).
// Valid/ready on both directions; one request in flight.
interface sha_const_fetch_if;
  import sha_const_fetch_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_sel;
  logic [IDX_W-1:0]  req_idx;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    output req_valid, req_sel, req_idx, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_sel, req_idx, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/sha_const_fetch_wait_timer.sv
// Loadable down-counter; o_done is high while the count sits at zero.
// Load takes effect on the next edge; counting stalls at zero, no backpressure.
module sha_const_fetch_wait_timer #(
  parameter int W = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/sha_const_fetch.sv
// Sequences CE/OE/A on four byte-lane constant EEPROMs and returns the assembled word.
// WAIT_CYCLES+3 cycles per word (2 on range error); response held until consumer takes it.
module sha_const_fetch
  import sha_const_fetch_pkg::*;
#(
  parameter int WAIT_CYCLES = WAIT_DEF,
  parameter int K_BASE      = K_BASE_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  sha_const_fetch_if.slave     bus,
  output logic [ADDR_W-1:0]    o_a,
  output logic                 o_ce,
  output logic                 o_oe,
  output logic                 o_we,
  input  logic [LANE_W-1:0]    i_io_1,
  input  logic [LANE_W-1:0]    i_io_2,
  input  logic [LANE_W-1:0]    i_io_3,
  input  logic [LANE_W-1:0]    i_io_4
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  state_e            r_state;
  state_e            w_next;
  logic [ADDR_W-1:0] r_a;
  logic [DATA_W-1:0] r_data;
  logic              r_err;
  logic              r_rsp_vld;
  logic              w_in_range;
  logic              w_accept;
  logic              w_timer_load;
  logic              w_timer_en;
  logic              w_timer_done;
  logic              w_handshake;

  assign w_in_range  = idx_in_range(bus.req_sel, bus.req_idx);
  assign w_accept    = (r_state == ST_IDLE) && bus.req_valid;
  assign w_handshake = (r_state == ST_RESP) && r_rsp_vld && bus.rsp_ready;
  assign w_timer_en  = (r_state == ST_ACCESS);

  sha_const_fetch_wait_timer #(
    .W (CNT_W)
  ) u_wait_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_timer_load),
    .i_load_val (CNT_W'(WAIT_CYCLES - 1)),
    .i_en       (w_timer_en),
    .o_done     (w_timer_done)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_timer_load = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          w_next = w_in_range ? ST_SETUP : ST_RESP;
        end
      end
      ST_SETUP: begin
        w_next       = ST_ACCESS;
        w_timer_load = 1'b1;
      end
      ST_ACCESS: begin
        if (w_timer_done) begin
          w_next = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        w_next = ST_RESP;
      end
      ST_RESP: begin
        if (w_handshake) begin
          w_next = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Address is loaded only on accepted in-range requests, so it never moves while CE is low.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a       <= '0;
      r_data    <= '0;
      r_err     <= 1'b0;
      r_rsp_vld <= 1'b0;
    end else begin
      if (w_accept) begin
        r_err  <= !w_in_range;
        r_data <= '0;
        if (w_in_range) begin
          r_a <= rom_addr(bus.req_sel, bus.req_idx, K_BASE);
        end
      end
      if ((r_state == ST_ACCESS) && w_timer_done) begin
        r_data <= {i_io_1, i_io_2, i_io_3, i_io_4};
      end
      // Error responses spend one cycle in RESP before raising valid.
      if (r_state == ST_CAPTURE) begin
        r_rsp_vld <= 1'b1;
      end else if ((r_state == ST_RESP) && r_err && !r_rsp_vld) begin
        r_rsp_vld <= 1'b1;
      end else if (w_handshake) begin
        r_rsp_vld <= 1'b0;
      end
    end
  end

  assign bus.req_ready = (r_state == ST_IDLE);
  assign bus.rsp_valid = r_rsp_vld;
  assign bus.rsp_data  = r_data;
  assign bus.rsp_err   = r_err;

  assign o_a  = r_a;
  assign o_ce = (r_state != ST_ACCESS);
  assign o_oe = (r_state != ST_ACCESS);
  assign o_we = 1'b1;

endmodule

// File: tb/tb_sha_const_fetch.sv
// Scoreboard bench: driver pushes expected words, negedge monitor pops and compares on handshake.
module tb_sha_const_fetch;
  import sha_const_fetch_pkg::*;

  localparam int WAIT = 4;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic [12:0] addr;
    int          t_req;
    int          lat;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [12:0] o_a;
  logic        o_ce;
  logic        o_oe;
  logic        o_we;
  logic [7:0]  io_1, io_2, io_3, io_4;
  logic [31:0] rom_word;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   inv_bad = 0;
  int   cyc = 0;
  int   acc_cnt = 0;
  exp_t q[$];

  logic [31:0] h_tab [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  logic [31:0] k_tab [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  sha_const_fetch_if bus();

  sha_const_fetch #(.WAIT_CYCLES(WAIT), .K_BASE(8)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .bus    (bus),
    .o_a    (o_a),
    .o_ce   (o_ce),
    .o_oe   (o_oe),
    .o_we   (o_we),
    .i_io_1 (io_1),
    .i_io_2 (io_2),
    .i_io_3 (io_3),
    .i_io_4 (io_4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // EEPROM bank model: data is garbage until CE/OE have been low long enough.
  always @(posedge clk) acc_cnt <= (o_ce || o_oe) ? 0 : acc_cnt + 1;

  function automatic logic [31:0] lookup(input logic [12:0] a);
    if (a < 13'd8) return h_tab[a[2:0]];
    if (a < 13'd72) return k_tab[6'(a - 13'd8)];
    return 32'hdeadbeef;
  endfunction

  always_comb begin
    rom_word = 32'ha5a5a5a5;
    if (!o_ce && !o_oe && acc_cnt >= WAIT - 1) rom_word = lookup(o_a);
  end
  assign io_1 = rom_word[31:24];
  assign io_2 = rom_word[23:16];
  assign io_3 = rom_word[15:8];
  assign io_4 = rom_word[7:0];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: per-transaction CE accounting, stall stability and scoreboard pop.
  int          ce_cnt = 0;
  logic [12:0] acc_a = '0;
  logic        lat_done = 1'b0;
  logic [31:0] held = '0;
  logic        held_err = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      ce_cnt   = 0;
      lat_done = 1'b0;
    end else begin
      if (o_we !== 1'b1) inv_bad++;
      if (!o_ce) begin
        if (ce_cnt > 0 && o_a !== acc_a) inv_bad++;
        ce_cnt++;
        acc_a = o_a;
      end
      if (bus.rsp_valid) begin
        if (bus.req_ready) inv_bad++;
        if (q.size() == 0) begin
          check("rsp_without_req", 32'd1, 32'd0);
        end else begin
          if (!lat_done) begin
            check("latency", 32'(cyc - q[0].t_req), 32'(q[0].lat));
            lat_done = 1'b1;
            held     = bus.rsp_data;
            held_err = bus.rsp_err;
          end else if (bus.rsp_data !== held || bus.rsp_err !== held_err) begin
            inv_bad++;
          end
          if (bus.rsp_ready) begin
            exp_t e;
            e = q.pop_front();
            check("rsp_data", bus.rsp_data, e.data);
            check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
            check("ce_low_cycles", 32'(ce_cnt), e.err ? 32'd0 : 32'(WAIT));
            if (!e.err) check("eeprom_addr", 32'(acc_a), 32'(e.addr));
            ce_cnt   = 0;
            lat_done = 1'b0;
          end
        end
      end
    end
  end

  task automatic send(input logic sel, input logic [5:0] idx, input logic [31:0] d,
                      input logic e, input logic [12:0] a);
    int   n = 0;
    exp_t x;
    @(negedge clk);
    while (!bus.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      check("req_accept_timeout", 32'd1, 32'd0);
      return;
    end
    bus.req_valid = 1'b1;
    bus.req_sel   = sel;
    bus.req_idx   = idx;
    x.data = d; x.err = e; x.addr = a; x.t_req = cyc; x.lat = e ? 2 : 7;
    q.push_back(x);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("drain_timeout", 32'(q.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_sel   = 1'b0;
    bus.req_idx   = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_data", bus.rsp_data, 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst_a", 32'(o_a), 32'd0);
    check("rst_ce", 32'(o_ce), 32'd1);
    check("rst_oe", 32'(o_oe), 32'd1);
    check("rst_we", 32'(o_we), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    send(1'b0, 6'd0,  32'h6a09e667, 1'b0, 13'd0);
    send(1'b1, 6'd0,  32'h428a2f98, 1'b0, 13'd8);
    send(1'b1, 6'd63, 32'hc67178f2, 1'b0, 13'd71);
    send(1'b0, 6'd7,  32'h5be0cd19, 1'b0, 13'd7);
    send(1'b0, 6'd9,  32'h00000000, 1'b1, 13'd0);
    send(1'b1, 6'd2,  32'hb5c0fbcf, 1'b0, 13'd10);
    send(1'b0, 6'd3,  32'ha54ff53a, 1'b0, 13'd3);
    send(1'b0, 6'd63, 32'h00000000, 1'b1, 13'd0);
    send(1'b1, 6'd32, 32'h27b70a85, 1'b0, 13'd40);
    drain();

    // Consumer stall: response must sit still with the request side closed.
    bus.rsp_ready = 1'b0;
    send(1'b1, 6'd1, 32'h71374491, 1'b0, 13'd9);
    n = 0;
    while (!bus.rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    check("stall_valid_held", 32'(bus.rsp_valid), 32'd1);
    check("stall_req_ready", 32'(bus.req_ready), 32'd0);
    bus.rsp_ready = 1'b1;
    drain();

    // Reset in the middle of an EEPROM access abandons it silently.
    bus.req_valid = 1'b1;
    bus.req_sel   = 1'b1;
    bus.req_idx   = 6'd10;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    n = 0;
    while (o_ce && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("abort_ce_reached", 32'(o_ce), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_ce", 32'(o_ce), 32'd1);
    check("abort_oe", 32'(o_oe), 32'd1);
    check("abort_req_ready", 32'(bus.req_ready), 32'd1);
    check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);

    send(1'b0, 6'd1, 32'hbb67ae85, 1'b0, 13'd1);
    drain();

    check("scoreboard_empty", 32'(q.size()), 32'd0);
    check("invariants", 32'(inv_bad), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
